// File: rtl/sobel_frame_loader_if.sv
// Bundles the sobel frame loader's block handshake, pixel stream, RAM write port and sobel launch.
// master: upstream/control side that drives ap_start, the pixel stream and sobel_ap_done.
// slave:  the loader itself.
interface sobel_frame_loader_if #(
  parameter int PIX_W = 8,
  parameter int ROW_W = 9,
  parameter int COL_W = 9
) ();
  // block-level handshake
  logic                   ap_start;
  logic                   ap_done;
  logic                   ap_idle;
  logic                   ap_ready;
  // incoming pixel stream
  logic [PIX_W-1:0]       s_pix_tdata;
  logic                   s_pix_tvalid;
  logic                   s_pix_tready;
  logic                   s_pix_tlast;
  // indata RAM write port, address packed {row, col}
  logic [ROW_W+COL_W-1:0] indata_address0;
  logic                   indata_ce0;
  logic                   indata_we0;
  logic [PIX_W-1:0]       indata_d0;
  // sobel core launch / completion
  logic                   sobel_ap_start;
  logic                   sobel_ap_done;
  // sticky row-length error for the current frame
  logic                   frame_err;

  modport master (
    output ap_start, s_pix_tdata, s_pix_tvalid, s_pix_tlast, sobel_ap_done,
    input  ap_done, ap_idle, ap_ready, s_pix_tready,
    input  indata_address0, indata_ce0, indata_we0, indata_d0,
    input  sobel_ap_start, frame_err
  );

  modport slave (
    input  ap_start, s_pix_tdata, s_pix_tvalid, s_pix_tlast, sobel_ap_done,
    output ap_done, ap_idle, ap_ready, s_pix_tready,
    output indata_address0, indata_ce0, indata_we0, indata_d0,
    output sobel_ap_start, frame_err
  );
endinterface

// File: rtl/sobel_frame_loader.sv
// sobel_frame_loader: writes one IMG_W x IMG_H frame from an 8-bit pixel stream into the sobel
// core's indata RAM ({row, col} addressing), launches the core and waits for its done pulse.
// Latency: IDLE->LOAD 1 cycle, last pixel->sobel_ap_start 2 cycles, sobel_ap_done->ap_done 1 cycle.
// Backpressure: s_pix_tready is high for the whole LOAD state; one pixel per cycle, never stalls.
// Optional macro SOBEL_LOADER_LOCK_EN adds working_key[2:0]; only 3'b101 gives normal operation.
module sobel_frame_loader #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int COL_W = 9,
  parameter int ROW_W = 9,
  parameter int PIX_W = 8
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
`ifdef SOBEL_LOADER_LOCK_EN
  input  logic [2:0]          working_key,
`endif
  sobel_frame_loader_if.slave bus
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // one-hot state encoding
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LOAD   = 5'b00010,
    S_LAUNCH = 5'b00100,
    S_WAIT   = 5'b01000,
    S_DONE   = 5'b10000
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               err_q;
  logic               sobel_start_q;

  logic               in_idle;
  logic               in_load;
  logic               in_launch;
  logic               in_wait;
  logic               in_done;

  logic               hs;
  logic               col_last;
  logic               row_last;
  logic               row_end;
  logic               frame_end;
  logic               err_evt;
  logic               frame_go;
  logic               cnt_clr;
  logic [PIX_W-1:0]   pix;

  // key-gated detours; all inactive when the lock is absent or the key is correct
  logic               skip_load;
  logic               skip_sobel;
  logic               reload;

`ifdef SOBEL_LOADER_LOCK_EN
  assign skip_load  = ~working_key[0];
  assign skip_sobel =  working_key[1];
  assign reload     = ~working_key[2];
`else
  assign skip_load  = 1'b0;
  assign skip_sobel = 1'b0;
  assign reload     = 1'b0;
`endif

  assign in_idle   = (state == S_IDLE);
  assign in_load   = (state == S_LOAD);
  assign in_launch = (state == S_LAUNCH);
  assign in_wait   = (state == S_WAIT);
  assign in_done   = (state == S_DONE);

  // A beat is taken whenever LOAD sees tvalid; tready is a pure function of state.
  assign hs        = in_load & bus.s_pix_tvalid;
  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);
  // A row closes at the last column or at an early tlast, whichever comes first.
  assign row_end   = hs & (col_last | bus.s_pix_tlast);
  assign frame_end = row_end & row_last;
  // Error when tlast and the last column disagree: early tlast or missing tlast.
  assign err_evt   = hs & (col_last ^ bus.s_pix_tlast);
  assign frame_go  = in_idle & bus.ap_start;
  assign cnt_clr   = frame_go | (in_wait & bus.sobel_ap_done & reload);
  assign pix       = bus.s_pix_tdata;

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.ap_start) state_nxt = skip_load ? S_LAUNCH : S_LOAD;
      S_LOAD:   if (frame_end) state_nxt = skip_sobel ? S_DONE : S_LAUNCH;
      // a done pulse that lands while still launching is not lost
      S_LAUNCH: state_nxt = bus.sobel_ap_done ? S_DONE : S_WAIT;
      S_WAIT:   if (bus.sobel_ap_done) state_nxt = reload ? S_LOAD : S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: stream ready, RAM write port and block handshake
  always_comb begin
    bus.s_pix_tready    = in_load;
    bus.indata_ce0      = hs;
    bus.indata_we0      = hs;
    bus.indata_address0 = {row, col};
    bus.indata_d0       = pix;
    bus.ap_done         = in_done;
    bus.ap_ready        = in_done;
    bus.ap_idle         = in_idle & ~bus.ap_start;
    bus.sobel_ap_start  = sobel_start_q;
    bus.frame_err       = err_q;
  end

  // Column/row write pointer: cleared on frame start, advanced per accepted pixel
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (cnt_clr) begin
      col <= '0;
      row <= '0;
    end else if (hs) begin
      if (row_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Sticky frame error: cleared only when a new frame is accepted from IDLE
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_q <= 1'b0;
    end else if (frame_go) begin
      err_q <= 1'b0;
    end else if (err_evt) begin
      err_q <= 1'b1;
    end
  end

  // Registered sobel start: rises the cycle after LAUNCH entry, holds until done is seen
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sobel_start_q <= 1'b0;
    end else begin
      sobel_start_q <= (in_launch | in_wait) & ~bus.sobel_ap_done;
    end
  end

  // Structural invariants: state stays one-hot and ap_done is a single-cycle pulse
  a_onehot: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) $onehot(state));
  a_done_pulse: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
                                 bus.ap_done |=> !bus.ap_done);

endmodule

// File: doc/sobel_frame_loader.md
Name: sobel_frame_loader

Overview:
- Upstream stage of the sobel core; fills its 512x512 `indata` pixel RAM from an incoming 8-bit pixel stream.
- Once a full frame is written, launches the sobel core and waits for its completion.
- Presents the same ap_start/ap_done/ap_idle/ap_ready block-level handshake as the rest of the pipeline.
- RAM address packing is {row, col}, matching the sobel core's indexing.

Parameters:
- IMG_W, 512, pixels per row (power of two, ≤512).
- IMG_H, 512, rows per frame (≤512).
- COL_W, 9, column counter / address low-field width.
- ROW_W, 9, row counter / address high-field width.
- PIX_W, 8, pixel width.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  start one frame load+process; level, sampled in IDLE.
- ap_done  out  1  one-cycle pulse: frame processed by sobel.
- ap_idle  out  1  high in IDLE while ap_start is low.
- ap_ready  out  1  equals ap_done.
- s_pix_tdata  in  PIX_W  stream pixel.
- s_pix_tvalid  in  1  pixel valid.
- s_pix_tready  out  1  loader accepts pixel.
- s_pix_tlast  in  1  marks last pixel of a row.
- indata_address0  out  ROW_W+COL_W  RAM write address {row, col}.
- indata_ce0  out  1  RAM chip enable.
- indata_we0  out  1  RAM write enable.
- indata_d0  out  PIX_W  RAM write data.
- sobel_ap_start  out  1  start to sobel core.
- sobel_ap_done  in  1  sobel core done pulse.
- frame_err  out  1  sticky row-length error for the current frame.

Behaviour:
- Reset (async, ap_rst_n=0), all values immediate:
  - FSM=IDLE; col=0; row=0; frame_err=0.
  - Outputs: s_pix_tready=0, indata_ce0/we0=0, sobel_ap_start=0, ap_done=0, ap_ready=0.
  - ap_idle follows IDLE & !ap_start.
- States are one-hot: IDLE, LOAD, LAUNCH, WAIT, DONE.
- IDLE:
  - If ap_start=1, go to LOAD, clear col/row/frame_err.
  - Otherwise stay in IDLE.
- LOAD:
  - s_pix_tready=1 (combinational from state).
  - On a handshake (tvalid & tready), in the same cycle: indata_ce0=indata_we0=1, address={row,col}, d0=tdata. No stall, one pixel per cycle.
  - Handshake with col==IMG_W-1: col←0, row←row+1. If tlast=0, set frame_err (missing tlast; row still advances).
  - Handshake with col<IMG_W-1 and tlast=1: early end of row. col←0, row←row+1, set frame_err. Unwritten columns keep their old RAM contents.
  - Handshake otherwise: col←col+1.
  - A handshake that advances row to IMG_H (last row complete) goes to LAUNCH. Row never wraps inside a frame.
  - No handshake: counters hold.
- LAUNCH:
  - sobel_ap_start=1 (registered, rises the cycle after entry).
  - Next state is WAIT.
- WAIT:
  - sobel_ap_start held at 1 until sobel_ap_done=1 is seen.
  - On sobel_ap_done: drop sobel_ap_start next cycle, go to DONE.
  - A sobel_ap_done arriving in LAUNCH is also honoured (go directly to DONE).
- DONE:
  - ap_done=ap_ready=1 for exactly one cycle, then IDLE.
  - If ap_start is still high, the next frame starts from IDLE one cycle later. No back-to-back merging.
- ap_start deasserting mid-frame is ignored; the frame completes.
- Reset mid-frame aborts immediately; the RAM is not cleared.
- Latency: IDLE→LOAD is 1 cycle; last pixel → sobel_ap_start high is 2 cycles; sobel_ap_done → ap_done is 1 cycle.

Optional Feature:
- Macro: SOBEL_LOADER_LOCK_EN.
- When defined:
  - Adds input working_key [2:0]. The correct key is 3'b101.
  - The FSM gains key-gated dummy transitions, matching the pipeline's locking style:
    - key[0]=0: IDLE+ap_start goes to LAUNCH, skipping LOAD.
    - key[1]=1: LOAD completion goes to DONE, skipping sobel.
    - key[2]=0: WAIT on sobel_ap_done returns to LOAD with counters cleared.
  - With key 3'b101, behaviour is identical to the base design.
- When undefined: no working_key port; the base FSM only.

Test Plan:
- Nominal frame (IMG_W=4, IMG_H=3):
  - Stimulus: ap_start; 12 pixels 0x01..0x0C with tlast on every 4th; sobel_ap_done 5 cycles after sobel_ap_start.
  - Required: writes to addresses {0,0}..{2,3} with matching data; sobel_ap_start high until done; a single ap_done pulse; frame_err=0.
- Backpressure / gaps:
  - Stimulus: tvalid toggling 1,0,0,1 through the frame.
  - Required: we0 only on handshake cycles; address sequence unchanged; total 12 writes.
- Early tlast:
  - Stimulus: row 1 gives tlast at col 1.
  - Required: next pixel written at {2,0}; frame_err=1; after only 10 writes, LAUNCH occurs once row 2 completes.
- Missing tlast:
  - Stimulus: row 0 ends with tlast=0.
  - Required: row still advances; frame_err=1.
- Reset mid-operation:
  - Stimulus: ap_rst_n low during WAIT.
  - Required: sobel_ap_start=0 and FSM=IDLE immediately; ap_idle=1 once ap_start is low.
- Lock (macro defined):
  - Stimulus: key 3'b101.
  - Required: identical to the nominal test.
  - Stimulus: key 3'b100.
  - Required: no RAM writes; sobel_ap_start asserted 2 cycles after ap_start.
